// File: rtl/led_sequencer.sv
// LED pattern sequencer: a synchronised slow tick steps the LED pattern, and a
// debounced, active-low mode button cycles through four pattern modes.
module led_sequencer #(
  parameter int LED_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 CLK_IN,
  input  logic                 RST_N,
  input  logic                 TICK_IN,
  input  logic                 BTN_N,
  output logic [LED_WIDTH-1:0] LED_OUT,
  output logic [1:0]           MODE_OUT,
  output logic                 STEP_OUT
);

  localparam int                   CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LED_WIDTH-1:0] LED_ONE  = LED_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_MSB  = LED_ONE << (LED_WIDTH - 1);

  typedef enum logic [1:0] {
    SHIFT_L = 2'd0,
    SHIFT_R = 2'd1,
    BOUNCE  = 2'd2,
    COUNT   = 2'd3
  } mode_t;

  mode_t                state, state_nxt;
  logic                 s1, s2, s3;
  logic                 step_ev;
  logic                 b1, b2, btn_stable;
  logic [CNT_W-1:0]     db_cnt;
  logic                 db_accept, press_ev;
  logic [LED_WIDTH-1:0] led_nxt;
  logic                 dir_up, dir_nxt, step_nxt;

  // Tick synchroniser plus delay flop for rising-edge detection
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= TICK_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step_ev = s2 & ~s3;

  // Button synchroniser, idles released (high)
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      b1 <= 1'b1;
      b2 <= 1'b1;
    end else begin
      b1 <= BTN_N;
      b2 <= b1;
    end
  end

  // The stable level flips on the same edge that raises the press event,
  // so the mode change lands on the edge that accepts the new level.
  assign db_accept = (b2 != btn_stable) && (db_cnt == CNT_LAST);
  assign press_ev  = db_accept && !b2;

  // Debounce counter and accepted button level
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      btn_stable <= 1'b1;
      db_cnt     <= '0;
    end else if (b2 != btn_stable) begin
      if (db_cnt == CNT_LAST) begin
        btn_stable <= b2;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Mode state register
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) state <= SHIFT_L;
    else        state <= state_nxt;
  end

  // Mode advances one step per press event
  always_comb begin
    state_nxt = state;
    if (press_ev) begin
      case (state)
        SHIFT_L: state_nxt = SHIFT_R;
        SHIFT_R: state_nxt = BOUNCE;
        BOUNCE:  state_nxt = COUNT;
        COUNT:   state_nxt = SHIFT_L;
        default: state_nxt = SHIFT_L;
      endcase
    end
  end

  // Next LED pattern: a press loads the new mode's seed and discards any step
  always_comb begin
    led_nxt  = LED_OUT;
    dir_nxt  = dir_up;
    step_nxt = 1'b0;
    if (press_ev) begin
      case (state_nxt)
        SHIFT_L: led_nxt = LED_ONE;
        SHIFT_R: led_nxt = LED_MSB;
        BOUNCE: begin
          led_nxt = LED_ONE;
          dir_nxt = 1'b1;
        end
        COUNT:   led_nxt = '0;
        default: led_nxt = LED_ONE;
      endcase
    end else if (step_ev) begin
      step_nxt = 1'b1;
      case (state)
        SHIFT_L: led_nxt = {LED_OUT[LED_WIDTH-2:0], LED_OUT[LED_WIDTH-1]};
        SHIFT_R: led_nxt = {LED_OUT[0], LED_OUT[LED_WIDTH-1:1]};
        BOUNCE: begin
          if (dir_up) begin
            led_nxt = LED_OUT << 1;
            if (led_nxt[LED_WIDTH-1]) dir_nxt = 1'b0;
          end else begin
            led_nxt = LED_OUT >> 1;
            if (led_nxt[0]) dir_nxt = 1'b1;
          end
        end
        COUNT:   led_nxt = LED_OUT + LED_ONE;
        default: led_nxt = LED_OUT;
      endcase
    end
  end

  // Registered LED pattern, bounce direction and step pulse
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      LED_OUT  <= LED_ONE;
      dir_up   <= 1'b1;
      STEP_OUT <= 1'b0;
    end else begin
      LED_OUT  <= led_nxt;
      dir_up   <= dir_nxt;
      STEP_OUT <= step_nxt;
    end
  end

  assign MODE_OUT = state;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: an edge-history behavioural model
// compared every cycle, plus directed literal expectations.
module tb_led_sequencer;

  localparam int W  = 4;
  localparam int DB = 4;

  logic         CLK_IN = 1'b0;
  logic         RST_N  = 1'b0;
  logic         TICK_IN = 1'b0;
  logic         BTN_N  = 1'b1;
  logic [W-1:0] LED_OUT;
  logic [1:0]   MODE_OUT;
  logic         STEP_OUT;

  int checks = 0;
  int passes = 0;
  int step_cnt = 0;

  led_sequencer #(.LED_WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK_IN  (CLK_IN),
    .RST_N   (RST_N),
    .TICK_IN (TICK_IN),
    .BTN_N   (BTN_N),
    .LED_OUT (LED_OUT),
    .MODE_OUT(MODE_OUT),
    .STEP_OUT(STEP_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int tick_hist [3];  // tick samples at the last three edges, [0] newest
  int btn_hist  [2];  // button samples at the last two edges
  int m_stable, m_run, m_mode, m_led, m_pos, m_up, m_step;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) tick_hist[i] = 0;
    for (int i = 0; i < 2; i++) btn_hist[i] = 1;
    m_stable = 1; m_run = 0;
    m_mode = 0; m_led = 1; m_pos = 0; m_up = 1; m_step = 0;
  endtask

  task automatic m_edge(input int tick, input int btn);
    int rise, press, synced;
    // tick rose two edges ago (seen high two edges back, low three back)
    rise   = (tick_hist[1] == 1 && tick_hist[2] == 0);
    synced = btn_hist[1];
    press  = 0;
    if (synced != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = synced;
        m_run = 0;
        press = (synced == 0);
      end
    end else m_run = 0;

    m_step = 0;
    if (press) begin
      m_mode = (m_mode + 1) % 4;
      case (m_mode)
        0: m_led = 1;
        1: m_led = 1 << (W - 1);
        2: begin m_pos = 0; m_up = 1; m_led = 1; end
        default: m_led = 0;
      endcase
    end else if (rise) begin
      m_step = 1;
      case (m_mode)
        0: m_led = ((m_led * 2) % (1 << W)) + (m_led >> (W - 1));
        1: m_led = (m_led / 2) + ((m_led % 2) << (W - 1));
        2: begin
          if (m_up) begin m_pos++; if (m_pos == W - 1) m_up = 0; end
          else      begin m_pos--; if (m_pos == 0)     m_up = 1; end
          m_led = 1 << m_pos;
        end
        default: m_led = (m_led + 1) % (1 << W);
      endcase
    end
    tick_hist[2] = tick_hist[1]; tick_hist[1] = tick_hist[0]; tick_hist[0] = tick;
    btn_hist[1]  = btn_hist[0];  btn_hist[0]  = btn;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK_IN or negedge RST_N);
      if (!RST_N) m_reset();
      else        m_edge(int'(TICK_IN), int'(BTN_N));
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge CLK_IN);
      chk("model_led",  int'(LED_OUT),  m_led);
      chk("model_mode", int'(MODE_OUT), m_mode);
      chk("model_step", int'(STEP_OUT), m_step);
      if (STEP_OUT) step_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK_IN);
    #1;
  endtask

  task automatic tick();
    TICK_IN = 1'b1; wait_cyc(4);
    TICK_IN = 1'b0; wait_cyc(4);
  endtask

  task automatic press();
    BTN_N = 1'b0; wait_cyc(10);
    BTN_N = 1'b1; wait_cyc(10);
  endtask

  int shl_exp   [5] = '{2, 4, 8, 1, 2};
  int bounce_exp[8] = '{2, 4, 8, 4, 2, 1, 2, 4};
  int sc;

  initial begin
    wait_cyc(3);
    chk("reset_led",  int'(LED_OUT), 1);
    chk("reset_mode", int'(MODE_OUT), 0);
    chk("reset_step", int'(STEP_OUT), 0);
    RST_N = 1'b1;
    wait_cyc(3);

    // SHIFT_L: first tick with latency pinned, then the rest
    sc = step_cnt;
    TICK_IN = 1'b1;
    wait_cyc(2);
    chk("lat_edge2_led",  int'(LED_OUT), 1);
    chk("lat_edge2_step", int'(STEP_OUT), 0);
    wait_cyc(1);
    chk("lat_edge3_led",  int'(LED_OUT), 2);
    chk("lat_edge3_step", int'(STEP_OUT), 1);
    wait_cyc(1);
    chk("lat_pulse_end", int'(STEP_OUT), 0);
    TICK_IN = 1'b0; wait_cyc(4);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("shl_led", int'(LED_OUT), shl_exp[i]);
    end
    chk("shl_steps", step_cnt - sc, 5);

    // Short glitch on the button is rejected
    BTN_N = 1'b0; wait_cyc(3);
    BTN_N = 1'b1; wait_cyc(10);
    chk("glitch_mode", int'(MODE_OUT), 0);

    // Real press: mode changes on the sixth edge after BTN_N falls
    BTN_N = 1'b0;
    wait_cyc(5);
    chk("press_pre_mode", int'(MODE_OUT), 0);
    wait_cyc(1);
    chk("press_mode", int'(MODE_OUT), 1);
    chk("press_led",  int'(LED_OUT), 8);
    wait_cyc(4);
    BTN_N = 1'b1; wait_cyc(12);
    chk("release_mode", int'(MODE_OUT), 1);
    chk("release_led",  int'(LED_OUT), 8);

    // BOUNCE
    press();
    chk("bounce_mode", int'(MODE_OUT), 2);
    chk("bounce_init", int'(LED_OUT), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bounce_led", int'(LED_OUT), bounce_exp[i]);
    end

    // COUNT: wrap from all ones
    press();
    chk("count_mode", int'(MODE_OUT), 3);
    chk("count_init", int'(LED_OUT), 0);
    for (int i = 0; i < 15; i++) tick();
    chk("count_15", int'(LED_OUT), 15);
    sc = step_cnt;
    tick();
    chk("count_wrap", int'(LED_OUT), 0);
    chk("count_wrap_step", step_cnt - sc, 1);

    // Back to SHIFT_L, then press and step on the same edge
    press();
    chk("wrap_mode", int'(MODE_OUT), 0);
    chk("wrap_led",  int'(LED_OUT), 1);
    sc = step_cnt;
    BTN_N = 1'b0;
    wait_cyc(3);
    TICK_IN = 1'b1;
    wait_cyc(2);
    chk("coll_pre_mode", int'(MODE_OUT), 0);
    wait_cyc(1);
    chk("coll_mode", int'(MODE_OUT), 1);
    chk("coll_led",  int'(LED_OUT), 8);
    chk("coll_step", int'(STEP_OUT), 0);
    wait_cyc(1);
    chk("coll_step_next", int'(STEP_OUT), 0);
    TICK_IN = 1'b0; wait_cyc(4);
    BTN_N = 1'b1; wait_cyc(10);
    chk("coll_steps", step_cnt - sc, 0);

    // Into COUNT, load 3, then asynchronous reset pulse between edges
    press();
    press();
    chk("count2_mode", int'(MODE_OUT), 3);
    for (int i = 0; i < 3; i++) tick();
    chk("count2_led", int'(LED_OUT), 3);
    @(negedge CLK_IN);
    #1;
    TICK_IN = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("async_led",  int'(LED_OUT), 1);
    chk("async_mode", int'(MODE_OUT), 0);
    chk("async_step", int'(STEP_OUT), 0);
    #1;
    RST_N = 1'b1;
    sc = step_cnt;
    wait_cyc(2);
    chk("rel_edge2_led", int'(LED_OUT), 1);
    wait_cyc(1);
    chk("rel_edge3_led",  int'(LED_OUT), 2);
    chk("rel_edge3_step", int'(STEP_OUT), 1);
    wait_cyc(12);
    chk("rel_hold_led", int'(LED_OUT), 2);
    chk("rel_steps", step_cnt - sc, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
